// File: rtl/r5fp_fmac_retire.sv
// r5fp_fmac_retire
//   Retire stage for the fused multiply-add pipe. Results are buffered in a
//   2-entry FIFO. At push time each result is NaN-canonicalised and its FMA
//   status word is turned into RISC-V style flags. Each pop advances a
//   16-bit retire counter.
//
//   Build option: define R5FP_FFLAGS_ACC_EN to get the sticky fflags
//   accumulator and its fflags_clr input. When it is not defined, fflags
//   reads 0 and fflags_clr is ignored.
//
//   Ports
//     clk         sole clock, rising edge
//     reset       asynchronous, active-low reset
//     in_valid    FMA result offered by upstream
//     in_ready    buffer can take in_z/in_status this cycle
//     in_z        FMA result {sign,exp,frac}
//     in_status   FMA status word (bit positions per Z_* macros)
//     out_valid   retired result at head of buffer
//     out_ready   downstream consumes the head result
//     out_z       canonicalised result at head of buffer
//     out_flags   per-op flags {NV,DZ,OF,UF,NX} of the head result
//     fflags_clr  synchronous clear of the sticky flags
//     fflags      sticky accumulated flags {NV,DZ,OF,UF,NX}
//     retire_cnt  count of retired results, wraps at 16 bits

// Status word bit positions; these match the R5FP_inc.vh defaults and are
// defined here only if that header has not already been included.
`ifndef Z_IS_ZERO
`define Z_IS_ZERO     0
`endif
`ifndef Z_IS_INF
`define Z_IS_INF      1
`endif
`ifndef Z_INVALID
`define Z_INVALID     2
`endif
`ifndef Z_TINY
`define Z_TINY        3
`endif
`ifndef Z_HUGE
`define Z_HUGE        4
`endif
`ifndef Z_INEXACT
`define Z_INEXACT     5
`endif

module r5fp_fmac_retire #(
    parameter int EXP_W = 8,
    parameter int SIG_W = 23
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+SIG_W:0]   in_z,
    input  logic [7:0]             in_status,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+SIG_W:0]   out_z,
    output logic [4:0]             out_flags,
    input  logic                   fflags_clr,
    output logic [4:0]             fflags,
    output logic [15:0]            retire_cnt
);

    localparam int W = EXP_W + SIG_W + 1;

    logic [W-1:0] z_mem [2];
    logic [4:0]   f_mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   occ;
    logic         alive;     // low in reset, high from the first edge after release
    logic         push;
    logic         pop;
    logic [W-1:0] z_canon;
    logic [4:0]   flags_new;

    assign in_ready  = alive & (occ != 2'd2);
    assign out_valid = (occ != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // The head entry is read straight from storage. There is therefore no
    // combinational path from the inputs to out_*, and the head stays stable
    // while it is stalled.
    assign out_z     = z_mem[rd_ptr];
    assign out_flags = f_mem[rd_ptr];

    // Any NaN becomes the canonical quiet NaN: +, exp all-ones, frac MSB only.
    always_comb begin
        z_canon = in_z;
        if ((&in_z[W-2:SIG_W]) && (|in_z[SIG_W-1:0])) begin
            z_canon              = '0;
            z_canon[W-2:SIG_W]   = '1;
            z_canon[SIG_W-1]     = 1'b1;
        end
    end

    // Underflow is reported only when the tiny result is also inexact.
    // The FMA cannot divide by zero, so DZ is always 0.
    assign flags_new = {in_status[`Z_INVALID],
                        1'b0,
                        in_status[`Z_HUGE],
                        in_status[`Z_TINY] & in_status[`Z_INEXACT],
                        in_status[`Z_INEXACT]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alive      <= 1'b0;
            occ        <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            z_mem[0]   <= '0;
            z_mem[1]   <= '0;
            f_mem[0]   <= '0;
            f_mem[1]   <= '0;
            retire_cnt <= '0;
        end else begin
            alive <= 1'b1;
            if (push) begin
                z_mem[wr_ptr] <= z_canon;
                f_mem[wr_ptr] <= flags_new;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr     <= ~rd_ptr;
                retire_cnt <= retire_cnt + 16'd1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

`ifdef R5FP_FFLAGS_ACC_EN
    // When a clear and a pop happen in the same cycle, the clear is applied
    // first, so the register ends up holding only the popped entry's flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fflags <= '0;
        end else if (pop) begin
            fflags <= (fflags_clr ? 5'b0 : fflags) | out_flags;
        end else if (fflags_clr) begin
            fflags <= '0;
        end
    end
`else
    logic unused_fflags_clr;
    assign unused_fflags_clr = fflags_clr;
    assign fflags            = '0;
`endif

endmodule

// File: tb/tb_r5fp_fmac_retire.sv
`timescale 1ns/1ps
module tb_r5fp_fmac_retire;

    // Status bit positions of the FMA status word.
    localparam int ST_INVALID = 2;
    localparam int ST_TINY    = 3;
    localparam int ST_HUGE    = 4;
    localparam int ST_INEXACT = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_z = '0;
    logic [7:0]  in_status = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_z;
    logic [4:0]  out_flags;
    logic        fflags_clr = 1'b0;
    logic [4:0]  fflags;
    logic [15:0] retire_cnt;

    r5fp_fmac_retire #(.EXP_W(8), .SIG_W(23)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_z       (in_z),
        .in_status  (in_status),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_z      (out_z),
        .out_flags  (out_flags),
        .fflags_clr (fflags_clr),
        .fflags     (fflags),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int failed    = 0;

    // Reference model: a queue of the values in flight, plus counters.
    typedef struct {
        logic [31:0] z;
        logic [4:0]  f;
    } ent_t;

    ent_t        q[$];
    logic [15:0] m_cnt   = '0;
    logic [4:0]  m_ff    = '0;
    bit          m_alive = 1'b0;
    bit          quiet   = 1'b0;

    typedef struct {
        logic [31:0] z;
        logic [7:0]  s;
        logic [31:0] ez;
        logic [4:0]  ef;
    } vec_t;

    vec_t vt[9];

    function automatic logic [31:0] canon(input logic [31:0] z);
        if (z[30:23] == 8'hFF && z[22:0] != 23'd0)
            return 32'h7FC0_0000;
        return z;
    endfunction

    function automatic logic [4:0] mkflags(input logic [7:0] s);
        logic nv, of, uf, nx;
        nv = s[ST_INVALID];
        of = s[ST_HUGE];
        nx = s[ST_INEXACT];
        uf = s[ST_TINY] && nx;
        return {nv, 1'b0, of, uf, nx};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("in_ready",   32'(in_ready),   32'(m_alive && q.size() < 2));
        check("out_valid",  32'(out_valid),  32'(q.size() != 0));
        check("retire_cnt", 32'(retire_cnt), 32'(m_cnt));
        check("fflags",     32'(fflags),     32'(m_ff));
        if (q.size() != 0) begin
            check("out_z",     out_z,          q[0].z);
            check("out_flags", 32'(out_flags), 32'(q[0].f));
        end
    endtask

    // Apply the current inputs across one rising edge, update the model, and
    // compare the outputs 1 ns after the edge.
    task automatic step();
        bit   m_push, m_pop;
        ent_t e;
        m_pop  = (q.size() != 0) && out_ready;
        m_push = in_valid && m_alive && (q.size() < 2);
        if (m_pop) begin
            e = q.pop_front();
            m_cnt = m_cnt + 16'd1;
`ifdef R5FP_FFLAGS_ACC_EN
            m_ff = (fflags_clr ? 5'b0 : m_ff) | e.f;
`endif
        end
`ifdef R5FP_FFLAGS_ACC_EN
        else if (fflags_clr) m_ff = '0;
`endif
        if (m_push) q.push_back('{canon(in_z), mkflags(in_status)});
        m_alive = 1'b1;
        @(posedge clk);
        #1;
        if (!quiet) check_outputs();
    endtask

    task automatic model_reset();
        q.delete();
        m_cnt   = '0;
        m_ff    = '0;
        m_alive = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"},  32'(out_valid),  32'd0);
        check({tag, "_in_ready"},   32'(in_ready),   32'd0);
        check({tag, "_out_z"},      out_z,           32'd0);
        check({tag, "_out_flags"},  32'(out_flags),  32'd0);
        check({tag, "_fflags"},     32'(fflags),     32'd0);
        check({tag, "_retire_cnt"}, 32'(retire_cnt), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        logic [31:0] rz;

        vt[0] = '{32'h7FC0_0001, 8'h04, 32'h7FC0_0000, 5'b10000};
        vt[1] = '{32'hFFC0_0000, 8'h00, 32'h7FC0_0000, 5'b00000};
        vt[2] = '{32'h3F80_0000, 8'h00, 32'h3F80_0000, 5'b00000};
        vt[3] = '{32'h7F80_0000, 8'h30, 32'h7F80_0000, 5'b00101};
        vt[4] = '{32'hFF80_0001, 8'h08, 32'h7FC0_0000, 5'b00000};
        vt[5] = '{32'h0000_0001, 8'h28, 32'h0000_0001, 5'b00011};
        vt[6] = '{32'h8000_0000, 8'hFF, 32'h8000_0000, 5'b10111};
        vt[7] = '{32'h7FFF_FFFF, 8'h20, 32'h7FC0_0000, 5'b00001};
        vt[8] = '{32'hFFFF_FFFF, 8'h00, 32'h7FC0_0000, 5'b00000};

        // Power-on reset.
        reset = 1'b1;
        #2 reset = 1'b0;
        #1 check_reset_values("por");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        m_alive = 1'b1;
        check_outputs();
        check("por_in_ready_after", 32'(in_ready), 32'd1);

        // Vector table: each result appears on the cycle after its push.
        foreach (vt[i]) begin
            in_valid  = 1'b1;
            in_z      = vt[i].z;
            in_status = vt[i].s;
            out_ready = 1'b0;
            step();
            check("vec_z",     out_z,          vt[i].ez);
            check("vec_flags", 32'(out_flags), 32'(vt[i].ef));
            in_valid  = 1'b0;
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end

        // Order is kept: a NaN followed by 1.0.
        in_status = '0;
        in_valid  = 1'b1;
        in_z      = 32'hFFC0_0000; step();
        in_z      = 32'h3F80_0000; step();
        check("order_first", out_z, 32'h7FC0_0000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("order_second", out_z, 32'h3F80_0000);
        step();
        check("order_empty", 32'(out_valid), 32'd0);

        // Full buffer: the third push is ignored and the head stays stable.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_z = 32'h4000_0000; step();
        check("full_rdy1", 32'(in_ready), 32'd1);
        in_z = 32'h4040_0000; step();
        check("full_rdy2", 32'(in_ready), 32'd0);
        check("full_head2", out_z, 32'h4000_0000);
        in_z = 32'h4080_0000; step();
        check("full_rdy3", 32'(in_ready), 32'd0);
        check("full_head3", out_z, 32'h4000_0000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("full_second", out_z, 32'h4040_0000);
        step();
        check("full_third_dropped", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Sticky flags: a clear that coincides with a pop keeps only the popped flags.
        fflags_clr = 1'b1; step();
        fflags_clr = 1'b0;
        in_valid = 1'b1; in_z = 32'h7FC0_0001; in_status = 8'h04; step();
        in_valid = 1'b0; out_ready = 1'b1; step();
`ifdef R5FP_FFLAGS_ACC_EN
        check("sticky_before", 32'(fflags), 32'h10);
`else
        check("sticky_before", 32'(fflags), 32'h00);
`endif
        out_ready = 1'b0;
        in_valid = 1'b1; in_z = 32'h0000_0001; in_status = 8'h28; step();
        in_valid = 1'b0; out_ready = 1'b1; fflags_clr = 1'b1; step();
`ifdef R5FP_FFLAGS_ACC_EN
        check("sticky_clr_pop", 32'(fflags), 32'h03);
`else
        check("sticky_clr_pop", 32'(fflags), 32'h00);
`endif
        fflags_clr = 1'b0;
        out_ready  = 1'b0;

        // Randomised traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            rz = $urandom;
            if ($urandom_range(0, 3) == 0) rz[30:23] = 8'hFF;
            if ($urandom_range(0, 7) == 0) rz[22:0]  = '0;
            in_z       = rz;
            in_status  = 8'($urandom);
            in_valid   = ($urandom_range(0, 2) != 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            fflags_clr = ($urandom_range(0, 7) == 0);
            step();
        end
        in_valid   = 1'b0;
        fflags_clr = 1'b0;
        out_ready  = 1'b1;
        step();
        step();
        check("drain_empty", 32'(out_valid), 32'd0);

        // retire_cnt wrap: stream pops until the count reaches 0xFFFF, then pop once more.
        quiet     = 1'b1;
        in_valid  = 1'b1;
        in_status = '0;
        out_ready = 1'b1;
        guard     = 0;
        while (m_cnt != 16'hFFFF && guard < 70000) begin
            in_z = $urandom;
            step();
            guard++;
        end
        quiet = 1'b0;
        check("wrap_at_ffff", 32'(retire_cnt), 32'h0000_FFFF);
        in_valid = 1'b0;
        step();
        check("wrap_to_zero", 32'(retire_cnt), 32'h0000_0000);

        // Reset with two entries buffered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_status = 8'h3C;
        in_z = 32'h1234_5678; step();
        in_z = 32'h7F80_0001; step();
        check("pre_reset_full", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1 check_reset_values("midrst");
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        m_alive = 1'b1;
        check_outputs();
        check("midrst_in_ready_after", 32'(in_ready), 32'd1);
        check("midrst_dropped", 32'(out_valid), 32'd0);

        // Normal operation after reset.
        in_valid = 1'b1; in_z = 32'h3F80_0000; in_status = '0; step();
        in_valid = 1'b0; out_ready = 1'b1; step();
        check("post_rst_cnt", 32'(retire_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
